// File: rtl/hsync_timing_gen.sv
// Horizontal timing generator: hsync, active window, repeated pixel address and line markers.
// Optional macro MEM_ALIGN_EN delays hsync/active/line_start/active_last by one stage to match a 1-cycle memory.
module hsync_timing_gen #(
    parameter int   H_SYNC     = 192,
    parameter int   H_BP       = 96,
    parameter int   H_ACTIVE   = 1280,
    parameter int   H_FP       = 32,
    parameter int   PIX_REPEAT = 10,
    parameter int   ADDR_W     = 7,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic              vga_hsync,
    output logic              active,
    output logic              read_mem,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              line_start,
    output logic              active_last
);

    localparam int H_MAX01 = (H_SYNC > H_BP) ? H_SYNC : H_BP;
    localparam int H_MAX23 = (H_ACTIVE > H_FP) ? H_ACTIVE : H_FP;
    localparam int H_MAX   = (H_MAX01 > H_MAX23) ? H_MAX01 : H_MAX23;
    localparam int CNT_W   = (H_MAX > 1) ? $clog2(H_MAX) : 1;
    localparam int REP_W   = (PIX_REPEAT > 1) ? $clog2(PIX_REPEAT) : 1;

    typedef enum logic [1:0] {S_SYNC, S_BP, S_ACT, S_FP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                act_end;

    logic                hsync_d, active_d, line_start_d, active_last_d;
    logic                hsync_q, active_q, line_start_q, active_last_q;
    logic [ADDR_W-1:0]   pix_d, pix_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            rep_q   <= '0;
            addr_q  <= '0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            addr_q  <= addr_d;
        end
    end

    assign act_end = (state_q == S_ACT) && (cnt_q == CNT_W'(H_ACTIVE - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_SYNC: if (cnt_q == CNT_W'(H_SYNC - 1)) begin state_d = S_BP;   cnt_d = '0; end
            S_BP:   if (cnt_q == CNT_W'(H_BP - 1))   begin state_d = S_ACT;  cnt_d = '0; end
            S_ACT:  if (act_end)                     begin state_d = S_FP;   cnt_d = '0; end
            S_FP:   if (cnt_q == CNT_W'(H_FP - 1))   begin state_d = S_SYNC; cnt_d = '0; end
            default:                                 begin state_d = S_SYNC; cnt_d = '0; end
        endcase

        // Address steps every PIX_REPEAT active cycles; cleared outside ACTIVE and on its last cycle.
        rep_d  = '0;
        addr_d = '0;
        if (state_q == S_ACT && !act_end) begin
            if (rep_q == REP_W'(PIX_REPEAT - 1)) begin
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                rep_d  = rep_q + REP_W'(1);
                addr_d = addr_q;
            end
        end
    end

    always_comb begin
        hsync_d       = (state_q == S_SYNC) ? SYNC_POL : ~SYNC_POL;
        active_d      = (state_q == S_ACT);
        pix_d         = addr_q;
        line_start_d  = (state_q == S_SYNC) && (cnt_q == '0);
        active_last_d = act_end;
    end

    // Registered decode of the current position; reset shows the decode of the last line cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            pix_q         <= '0;
            line_start_q  <= 1'b0;
            active_last_q <= 1'b0;
        end else if (en) begin
            hsync_q       <= hsync_d;
            active_q      <= active_d;
            pix_q         <= pix_d;
            line_start_q  <= line_start_d;
            active_last_q <= active_last_d;
        end
    end

    assign read_mem   = active_q;
    assign pixel_addr = pix_q;

`ifdef MEM_ALIGN_EN
    logic hsync_al_q, active_al_q, line_start_al_q, active_last_al_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_al_q       <= ~SYNC_POL;
            active_al_q      <= 1'b0;
            line_start_al_q  <= 1'b0;
            active_last_al_q <= 1'b0;
        end else if (en) begin
            hsync_al_q       <= hsync_q;
            active_al_q      <= active_q;
            line_start_al_q  <= line_start_q;
            active_last_al_q <= active_last_q;
        end
    end

    assign vga_hsync   = hsync_al_q;
    assign active      = active_al_q;
    assign line_start  = line_start_al_q;
    assign active_last = active_last_al_q;
`else
    assign vga_hsync   = hsync_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign active_last = active_last_q;
`endif

endmodule

// File: tb/tb_hsync_timing_gen.sv
// Scoreboard bench for hsync_timing_gen: default timing plus a small custom configuration.
module tb_hsync_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b1;
    always #5 clk = ~clk;

    logic       d0_hs, d0_act, d0_rd, d0_ls, d0_al;
    logic [6:0] d0_addr;
    logic       d1_hs, d1_act, d1_rd, d1_ls, d1_al;
    logic [0:0] d1_addr;

    hsync_timing_gen dut (
        .clk(clk), .reset(reset), .en(en),
        .vga_hsync(d0_hs), .active(d0_act), .read_mem(d0_rd),
        .pixel_addr(d0_addr), .line_start(d0_ls), .active_last(d0_al)
    );

    hsync_timing_gen #(
        .H_SYNC(4), .H_BP(2), .H_ACTIVE(6), .H_FP(2),
        .PIX_REPEAT(4), .ADDR_W(1), .SYNC_POL(1'b1)
    ) dut_small (
        .clk(clk), .reset(reset), .en(en),
        .vga_hsync(d1_hs), .active(d1_act), .read_mem(d1_rd),
        .pixel_addr(d1_addr), .line_start(d1_ls), .active_last(d1_al)
    );

`ifdef MEM_ALIGN_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    typedef struct packed {
        logic       hs;
        logic       act;
        logic       rd;
        logic [6:0] addr;
        logic       ls;
        logic       al;
    } out_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   k = 0;
    int   cfg = 0;
    int   m_sync, m_bp, m_act, m_fp, m_rep;
    logic m_pol;
    int   h = 0;
    out_t s1, s2, exp_o, act_o;
    out_t sb[$];

    function automatic out_t idle_val();
        out_t o = '0;
        o.hs = ~m_pol;
        return o;
    endfunction

    function automatic out_t decode(input int hh);
        out_t o = '0;
        int   as = m_sync + m_bp;
        logic in_act = (hh >= as) && (hh < as + m_act);
        o.hs   = (hh < m_sync) ? m_pol : ~m_pol;
        o.act  = in_act;
        o.rd   = in_act;
        o.addr = in_act ? 7'((hh - as) / m_rep) : 7'd0;
        o.ls   = (hh == 0);
        o.al   = (hh == as + m_act - 1);
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("hs=%b act=%b rd=%b addr=%0d ls=%b al=%b", o.hs, o.act, o.rd, o.addr, o.ls, o.al);
    endfunction

    task automatic set_cfg(input int c);
        cfg = c;
        if (c == 0) begin
            m_sync = 192; m_bp = 96; m_act = 1280; m_fp = 32; m_rep = 10; m_pol = 1'b0;
        end else begin
            m_sync = 4; m_bp = 2; m_act = 6; m_fp = 2; m_rep = 4; m_pol = 1'b1;
        end
    endtask

    // Drive one edge, push the model's prediction, then sample the DUT and pop the prediction.
    task automatic cycle(input logic r, input logic e);
        out_t x;
        reset = r;
        en    = e;
        if (r) begin
            h = 0; s1 = idle_val(); s2 = idle_val();
        end else if (e) begin
            s2 = s1;
            s1 = decode(h);
            h  = (h + 1) % (m_sync + m_bp + m_act + m_fp);
        end
        x = s1;
`ifdef MEM_ALIGN_EN
        x.hs = s2.hs; x.act = s2.act; x.ls = s2.ls; x.al = s2.al;
`endif
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (r) k = 0; else k++;
        if (cfg == 0) begin
            act_o.hs = d0_hs; act_o.act = d0_act; act_o.rd = d0_rd;
            act_o.addr = d0_addr; act_o.ls = d0_ls; act_o.al = d0_al;
        end else begin
            act_o.hs = d1_hs; act_o.act = d1_act; act_o.rd = d1_rd;
            act_o.addr = {6'b0, d1_addr}; act_o.ls = d1_ls; act_o.al = d1_al;
        end
        exp_o = sb.pop_front();
    endtask

    task automatic test_reset();
        out_t want;
        set_cfg(0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        want = '0;
        want.hs = 1'b1;
        n_cmp++;
        if (act_o !== want) begin
            n_err++;
            $display("FAIL reset_idle: got %s want %s", fmt(act_o), fmt(want));
        end
        n_cmp++;
        if (act_o !== exp_o) begin
            n_err++;
            $display("FAIL reset_sb: got %s want %s", fmt(act_o), fmt(exp_o));
        end
    endtask

    task automatic test_full_line();
        set_cfg(0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 1700; i++) begin
            cycle(1'b0, 1'b1);
            n_cmp++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL line_sb k=%0d: got %s want %s", k, fmt(act_o), fmt(exp_o));
            end
            if (k == 1 + D || k == 1601 + D) begin
                n_cmp++;
                if ({act_o.hs, act_o.ls} !== 2'b01) begin
                    n_err++;
                    $display("FAIL line_start k=%0d: got hs,ls=%b want 01", k, {act_o.hs, act_o.ls});
                end
            end
            if (k == 192 + D || k == 193 + D) begin
                n_cmp++;
                if (act_o.hs !== (k == 193 + D)) begin
                    n_err++;
                    $display("FAIL hsync_edge k=%0d: got %b want %b", k, act_o.hs, (k == 193 + D));
                end
            end
            if (k == 288 || k == 289 || k == 298 || k == 299 || k == 1559 || k == 1568 || k == 1569) begin
                logic [7:0] want;
                case (k)
                    288:     want = {1'b0, 7'd0};
                    289:     want = {1'b1, 7'd0};
                    298:     want = {1'b1, 7'd0};
                    299:     want = {1'b1, 7'd1};
                    1559:    want = {1'b1, 7'd127};
                    1568:    want = {1'b1, 7'd127};
                    default: want = {1'b0, 7'd0};
                endcase
                n_cmp++;
                if ({act_o.rd, act_o.addr} !== want) begin
                    n_err++;
                    $display("FAIL rd_addr k=%0d: got rd=%b addr=%0d want rd=%b addr=%0d",
                             k, act_o.rd, act_o.addr, want[7], want[6:0]);
                end
            end
            if (k == 288 + D || k == 289 + D || k == 1567 + D || k == 1568 + D || k == 1569 + D) begin
                logic [1:0] want;
                want = {(k >= 289 + D && k <= 1568 + D), (k == 1568 + D)};
                n_cmp++;
                if ({act_o.act, act_o.al} !== want) begin
                    n_err++;
                    $display("FAIL active_window k=%0d: got act,al=%b want %b", k, {act_o.act, act_o.al}, want);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        set_cfg(0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 1700; i++) begin
            cycle(1'b0, !(k + 1 >= 100 && k + 1 <= 104));
            n_cmp++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL hold_sb k=%0d: got %s want %s", k, fmt(act_o), fmt(exp_o));
            end
            if (k >= 99 && k <= 104) begin
                n_cmp++;
                if (act_o !== '0) begin
                    n_err++;
                    $display("FAIL hold_frozen k=%0d: got %s want all zero", k, fmt(act_o));
                end
            end
            if (k == 197 + D || k == 198 + D) begin
                n_cmp++;
                if (act_o.hs !== (k == 198 + D)) begin
                    n_err++;
                    $display("FAIL hold_hsync k=%0d: got %b want %b", k, act_o.hs, (k == 198 + D));
                end
            end
            if (k == 1605 + D || k == 1606 + D) begin
                n_cmp++;
                if (act_o.ls !== (k == 1606 + D)) begin
                    n_err++;
                    $display("FAIL hold_period k=%0d: got ls=%b want %b", k, act_o.ls, (k == 1606 + D));
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        out_t want;
        set_cfg(0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 499; i++) begin
            cycle(1'b0, 1'b1);
            n_cmp++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL mid_pre_sb k=%0d: got %s want %s", k, fmt(act_o), fmt(exp_o));
            end
        end
        cycle(1'b1, 1'b1);
        want = '0;
        want.hs = 1'b1;
        n_cmp++;
        if (act_o !== want) begin
            n_err++;
            $display("FAIL mid_reset: got %s want %s", fmt(act_o), fmt(want));
        end
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'b1);
            n_cmp++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL mid_post_sb k=%0d: got %s want %s", k, fmt(act_o), fmt(exp_o));
            end
            if (k == 1 + D) begin
                n_cmp++;
                if ({act_o.hs, act_o.ls} !== 2'b01) begin
                    n_err++;
                    $display("FAIL mid_release k=%0d: got hs,ls=%b want 01", k, {act_o.hs, act_o.ls});
                end
            end
        end
    endtask

    task automatic test_small_cfg();
        set_cfg(1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1);
            n_cmp++;
            if (act_o !== exp_o) begin
                n_err++;
                $display("FAIL small_sb k=%0d: got %s want %s", k, fmt(act_o), fmt(exp_o));
            end
            if (k >= 1 + D && k <= 5 + D) begin
                n_cmp++;
                if (act_o.hs !== (k <= 4 + D)) begin
                    n_err++;
                    $display("FAIL small_hsync k=%0d: got %b want %b", k, act_o.hs, (k <= 4 + D));
                end
            end
            if (k >= 6 && k <= 13) begin
                logic [1:0] want;
                want = {(k >= 7 && k <= 12), (k == 11 || k == 12)};
                n_cmp++;
                if ({act_o.rd, act_o.addr[0]} !== want || act_o.addr[6:1] !== 6'd0) begin
                    n_err++;
                    $display("FAIL small_addr k=%0d: got rd=%b addr=%0d want rd=%b addr=%0d",
                             k, act_o.rd, act_o.addr, want[1], want[0]);
                end
            end
            if (k == 14 + D || k == 15 + D || k == 29 + D) begin
                n_cmp++;
                if (act_o.ls !== (k != 14 + D)) begin
                    n_err++;
                    $display("FAIL small_period k=%0d: got ls=%b want %b", k, act_o.ls, (k != 14 + D));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 2; c++) begin
            set_cfg(c);
            cycle(1'b1, 1'b1);
            for (int i = 0; i < ((c == 0) ? 3000 : 400); i++) begin
                cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));
                n_cmp++;
                if (act_o !== exp_o) begin
                    n_err++;
                    $display("FAIL random_sb cfg=%0d i=%0d: got %s want %s", c, i, fmt(act_o), fmt(exp_o));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_enable_hold();
        test_reset_midline();
        test_small_cfg();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
